gcd: RTL and testbench

//   Iterative greatest-common-divisor engine using subtractive Euclid.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_if.sv | 21 ++
 rtl/gcd_datapath.sv | 50 +++++
 rtl/gcd.sv | 81 ++++++++
 tb/tb_gcd.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive-Euclid GCD engine.
// Optional build macro: GCD_RESTART_EN (start during RUN restarts the job).
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_if.sv
// Host-side bundle of the GCD engine: operands, start strobe, result, done.
// The host drives through master; the engine attaches through slave.
interface gcd_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic [WIDTH-1:0] answer;
    logic             done;

    modport master (
        output start, Ain, Bin,
        input  answer, done
    );

    modport slave (
        input  start, Ain, Bin,
        output answer, done
    );
endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, comparator flags and one shared subtractor.
// The larger operand is always the one reduced, so no underflow occurs.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             a_zero,
    output logic             b_zero,
    output logic             eq,
    output logic             gt
);

    logic [WIDTH-1:0] diff;

    // Comparator flags and larger-minus-smaller difference
    always_comb begin
        a_zero = (a == '0);
        b_zero = (b == '0);
        eq     = (a == b);
        gt     = (a > b);
        diff   = gt ? (a - b) : (b - a);
    end

    // Load operands on accept, otherwise reduce the larger one per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else if (load) begin
            a <= ain;
            b <= bin;
        end else if (step) begin
            if (gt) begin
                a <= diff;
            end else begin
                b <= diff;
            end
        end
    end

endmodule

// File: rtl/gcd.sv
// GCD engine top: control FSM plus registered answer and done flag.
// Build macro GCD_RESTART_EN lets a start in RUN reload and restart.
module gcd
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    gcd_if.slave  bus
);

    state_t           state;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_zero;
    logic             b_zero;
    logic             eq;
    logic             gt;

`ifdef GCD_RESTART_EN
    assign load = bus.start;
`else
    assign load = bus.start && (state != RUN);
`endif

    assign step = (state == RUN) && !load && !a_zero && !b_zero && !eq;

    gcd_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .ain    (bus.Ain),
        .bin    (bus.Bin),
        .a      (a),
        .b      (b),
        .a_zero (a_zero),
        .b_zero (b_zero),
        .eq     (eq),
        .gt     (gt)
    );

    // Control FSM; answer and done are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus.answer <= '0;
            bus.done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        bus.done <= 1'b0;
                    end
                end
                RUN: begin
                    if (load) begin
                        state <= RUN;
                    end else if (a_zero) begin
                        bus.answer <= b;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end else if (b_zero || eq) begin
                        bus.answer <= a;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd.sv
// Self-checking bench for gcd: scoreboard of expected answers plus
// latency counted in clock edges from the accepting edge.
module tb_gcd;

    localparam int W = 16;

    logic clk;
    logic rst_n;

    int compared;
    int mismatched;

    logic [W-1:0] exp_q[$];

    gcd_if #(.WIDTH(W)) bus ();

    gcd #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd_ref(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[W-1:0];
    endfunction

    function automatic int sub_steps(input int unsigned x, input int unsigned y);
        int n;
        n = 0;
        while (x != 0 && y != 0 && x != y) begin
            if (x > y) x = x - y;
            else y = y - x;
            n++;
        end
        return n;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Ain   = a;
        bus.Bin   = b;
        exp_q.push_back(gcd_ref(a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.Ain   = W'($urandom);
        bus.Bin   = W'($urandom);
        compared++;
        if (bus.done !== 1'b0) begin
            mismatched++;
            $display("FAIL %s done_drop: got %b want 0", name, bus.done);
        end
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int n;
        bit got;
        logic [W-1:0] exp;
        n = 0;
        got = 0;
        while (!got && n < exp_lat + 20) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done === 1'b1) got = 1;
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL %s timeout: no done after %0d edges, want %0d", name, n, exp_lat);
            return;
        end
        if (n != exp_lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d edges want %0d", name, n, exp_lat);
        end
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s scoreboard: got %0d want <empty queue>", name, bus.answer);
        end else begin
            exp = exp_q.pop_front();
            if (bus.answer !== exp) begin
                mismatched++;
                $display("FAIL %s answer: got %0d want %0d", name, bus.answer, exp);
            end
        end
    endtask

    task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        issue(a, b, name);
        wait_done(sub_steps(a, b) + 1, name);
    endtask

    task automatic test_reset;
        #1;
        compared++;
        if (bus.done !== 1'b0 || bus.answer !== '0) begin
            mismatched++;
            $display("FAIL reset: got done=%b answer=%0d want 0/0", bus.done, bus.answer);
        end
    endtask

    task automatic test_basic;
        int bad;
        issue(16'd21, 16'd15, "basic_21_15");
        wait_done(5, "basic_21_15");
        bad = 0;
        bus.Ain = 16'd99;
        bus.Bin = 16'd7;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            compared++;
            if (bus.done !== 1'b1 || bus.answer !== 16'd3) begin
                mismatched++;
                $display("FAIL hold cycle %0d: got done=%b answer=%0d want 1/3",
                         i, bus.done, bus.answer);
            end
        end
    endtask

    task automatic test_zero;
        issue(16'd0, 16'd9, "zero_a");
        wait_done(1, "zero_a");
        issue(16'd9, 16'd0, "zero_b");
        wait_done(1, "zero_b");
        issue(16'd0, 16'd0, "zero_both");
        wait_done(1, "zero_both");
    endtask

    task automatic test_equal;
        issue(16'd48, 16'd48, "equal_48");
        wait_done(1, "equal_48");
    endtask

    task automatic test_back_to_back;
        run_pair(16'd21, 16'd15, "b2b_first");
        issue(16'd100, 16'd75, "b2b_second");
        wait_done(4, "b2b_second");
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom_range(1, 255));
            b = W'($urandom_range(1, 255));
            run_pair(a, b, "random");
        end
    endtask

    task automatic test_restart;
        issue(16'd12, 16'd8, "restart");
        bus.Ain = 16'd35;
        bus.Bin = 16'd21;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        compared++;
        if (bus.done !== 1'b0) begin
            mismatched++;
            $display("FAIL restart early_done: got %b want 0", bus.done);
        end
`ifdef GCD_RESTART_EN
        void'(exp_q.pop_back());
        exp_q.push_back(16'd7);
        wait_done(4, "restart");
`else
        wait_done(1, "restart");
`endif
    endtask

    task automatic test_worst;
        issue(16'd1, 16'd65535, "worst_1_65535");
        wait_done(65535, "worst_1_65535");
    endtask

    task automatic test_reset_mid_run;
        issue(16'd1, 16'd65535, "mid_reset");
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.done !== 1'b0 || bus.answer !== '0) begin
            mismatched++;
            $display("FAIL mid_reset: got done=%b answer=%0d want 0/0", bus.done, bus.answer);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_pair(16'd21, 16'd15, "after_reset");
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.Ain    = '0;
        bus.Bin    = '0;
        repeat (2) @(posedge clk);
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_basic;
        test_zero;
        test_equal;
        test_back_to_back;
        test_random;
        test_restart;
        test_worst;
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
